// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - UART byte stream, CPU store port and BRAM port-B bundle
interface uart_boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_re;
  logic [10:0] cpu_addr;
  logic [31:0] cpu_din;
  logic        cpu_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic        core_hold;
  logic        boot_done;
  logic        boot_err;

  modport master (
    output rx_data, rx_valid, cpu_addr, cpu_din, cpu_we,
    input  rx_re, mem_addr, mem_din, mem_we, core_hold, boot_done, boot_err
  );

  modport slave (
    input  rx_data, rx_valid, cpu_addr, cpu_din, cpu_we,
    output rx_re, mem_addr, mem_din, mem_we, core_hold, boot_done, boot_err
  );
endinterface

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART frame loader filling BRAM port B, then handing it to the CPU
module uart_boot_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MEM_WORDS = 2048
) (
  input logic               clk,
  input logic               rst,
  uart_boot_loader_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CHK    = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;
  localparam logic [16:0] MAX_WORDS = 17'(MEM_WORDS);

  logic [2:0]  state;
  logic        rx_re_q;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [10:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] shift;
  logic [7:0]  acc;
  logic [3:0]  ld_we;
  logic [10:0] ld_addr;
  logic [31:0] ld_din;
  logic        accept;
  logic [15:0] n_words;
  logic        core_hold;

  // rx_re_q high means a byte was taken last cycle, which enforces the dead cycle
  assign accept    = bus.rx_valid && (state != DONE) && !rx_re_q;
  assign n_words   = {bus.rx_data, len_lo};
  assign core_hold = (state != DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rx_re_q  <= 1'b0;
      len_lo   <= 8'h00;
      len      <= 16'h0000;
      word_idx <= 11'd0;
      byte_idx <= 2'd0;
      shift    <= 24'h0;
      acc      <= 8'h00;
      ld_we    <= 4'h0;
      ld_addr  <= 11'd0;
      ld_din   <= 32'h0;
    end else begin
      rx_re_q <= accept;
      ld_we   <= 4'h0;
      if (accept) begin
        case (state)
          IDLE, ERR: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state    <= LEN_LO;
              word_idx <= 11'd0;
              byte_idx <= 2'd0;
              acc      <= 8'h00;
            end
          end
          LEN_LO: begin
            len_lo <= bus.rx_data;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            len <= n_words;
            if (n_words == 16'h0000)
              state <= CHK;
            else if ({1'b0, n_words} > MAX_WORDS)
              state <= ERR;
            else
              state <= DATA;
          end
          DATA: begin
            acc      <= acc ^ bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              ld_we   <= 4'hF;
              ld_addr <= word_idx;
              ld_din  <= {bus.rx_data, shift};
              // the index stops on the last word so it can never wrap past MEM_WORDS
              if ({5'b0, word_idx} == len - 16'd1)
                state <= CHK;
              else
                word_idx <= word_idx + 11'd1;
            end else begin
              shift <= {bus.rx_data, shift[23:8]};
            end
          end
          CHK: begin
            state <= (bus.rx_data == acc) ? DONE : ERR;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_re     = rx_re_q;
  assign bus.core_hold = core_hold;
  assign bus.boot_done = (state == DONE);
  assign bus.boot_err  = (state == ERR);
  assign bus.mem_addr  = core_hold ? ld_addr : bus.cpu_addr;
  assign bus.mem_din   = core_hold ? ld_din  : bus.cpu_din;
  assign bus.mem_we    = core_hold ? ld_we   : {4{bus.cpu_we}};
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - randomized frame stimulus against a frame-parsing reference model
module tb_uart_boot_loader;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int MEM_WORDS = 2048;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_boot_loader_if bus();
  uart_boot_loader #(.SYNC_BYTE(SYNC), .MEM_WORDS(MEM_WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  int cons_cnt = 0;
  int b2b_cnt = 0;
  logic prev_re = 1'b0;
  logic [10:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_we[$];
  logic [10:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic exp_done, exp_err;
  int exp_cons;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.rx_re) begin
        cons_cnt++;
        if (prev_re) b2b_cnt++;
      end
      if (bus.core_hold && bus.mem_we != 4'h0) begin
        got_addr.push_back(bus.mem_addr);
        got_data.push_back(bus.mem_din);
        got_we.push_back(bus.mem_we);
      end
    end
    prev_re = bus.rx_re;
  end

  // Parses the whole byte stream frame by frame and lists the BRAM writes it should cause
  task automatic model(input byte_q_t q);
    int i, n, len;
    logic [7:0] x;
    logic [31:0] w;
    i = 0; n = q.size();
    exp_addr.delete(); exp_data.delete();
    exp_done = 0; exp_err = 0; exp_cons = n;
    while (i < n) begin
      if (q[i] != SYNC) begin i++; continue; end
      i++; exp_err = 0;
      if (i + 2 > n) break;
      len = {q[i+1], q[i]}; i += 2;
      if (len > MEM_WORDS) begin exp_err = 1; continue; end
      x = 8'h00;
      for (int k = 0; k < len; k++) begin
        if (i + 4 > n) begin i = n; break; end
        w = {q[i+3], q[i+2], q[i+1], q[i]};
        x = x ^ q[i] ^ q[i+1] ^ q[i+2] ^ q[i+3];
        exp_addr.push_back(11'(k));
        exp_data.push_back(w);
        i += 4;
      end
      if (i >= n) break;
      if (q[i] == x) begin exp_done = 1; exp_cons = i + 1; break; end
      exp_err = 1; i++;
    end
  endtask

  task automatic send(input byte_q_t q);
    for (int i = 0; i < q.size(); i++) begin
      bit got;
      got = 0;
      bus.rx_data = q[i];
      bus.rx_valid = 1'b1;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        bus.cpu_we = 1'($urandom_range(0, 1));
        bus.cpu_addr = 11'($urandom);
        bus.cpu_din = $urandom;
        if (bus.rx_re) got = 1;
      end
      bus.rx_valid = 1'b0;
      if (!got) begin
        if (!bus.boot_done) check_eq("rx_timeout", 64'(got), 64'd1);
        break;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.cpu_we = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.cpu_we = 1'b0;
    @(posedge clk);
    got_addr.delete(); got_data.delete(); got_we.delete();
    cons_cnt = 0; b2b_cnt = 0;
    @(negedge clk);
    check_eq("rst_rx_re", 64'(bus.rx_re), 64'd0);
    check_eq("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check_eq("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check_eq("rst_mem_din", 64'(bus.mem_din), 64'd0);
    check_eq("rst_core_hold", 64'(bus.core_hold), 64'd1);
    check_eq("rst_boot_done", 64'(bus.boot_done), 64'd0);
    check_eq("rst_boot_err", 64'(bus.boot_err), 64'd0);
    rst = 1'b1;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "_nwr"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      check_eq({tag, "_addr"}, 64'(got_addr[k]), 64'(exp_addr[k]));
      check_eq({tag, "_data"}, 64'(got_data[k]), 64'(exp_data[k]));
      check_eq({tag, "_we"}, 64'(got_we[k]), 64'hF);
    end
    check_eq({tag, "_done"}, 64'(bus.boot_done), 64'(exp_done));
    check_eq({tag, "_err"}, 64'(bus.boot_err), 64'(exp_err));
    check_eq({tag, "_hold"}, 64'(bus.core_hold), 64'(!exp_done));
    check_eq({tag, "_consumed"}, 64'(cons_cnt), 64'(exp_cons));
    check_eq({tag, "_b2b"}, 64'(b2b_cnt), 64'd0);
  endtask

  task automatic run_case(input string tag, input byte_q_t q);
    do_reset();
    model(q);
    send(q);
    compare_all(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t q, p1, p2;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    bus.cpu_addr = 11'd0; bus.cpu_din = 32'h0; bus.cpu_we = 1'b0;
    repeat (2) @(negedge clk);

    q = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08, 8'h3C, 8'hA5};
    run_case("one_word", q);
    bus.cpu_we = 1'b1; bus.cpu_addr = 11'd5; bus.cpu_din = 32'hDEADBEEF;
    #1;
    check_eq("cpu_mem_we", 64'(bus.mem_we), 64'hF);
    check_eq("cpu_mem_addr", 64'(bus.mem_addr), 64'd5);
    check_eq("cpu_mem_din", 64'(bus.mem_din), 64'hDEADBEEF);
    bus.cpu_we = 1'b0;

    p1 = {8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
    p2 = {8'hA5, 8'h00, 8'h00, 8'h00};
    do_reset();
    model({p1, p2});
    send(p1);
    check_eq("bad_chk_err", 64'(bus.boot_err), 64'd1);
    check_eq("bad_chk_hold", 64'(bus.core_hold), 64'd1);
    check_eq("bad_chk_nwr", 64'(got_addr.size()), 64'd2);
    send(p2);
    compare_all("retry");

    q = {8'hA5, 8'h01, 8'h08, 8'h00, 8'h00};
    run_case("too_long", q);

    do_reset();
    send({8'hA5, 8'h01, 8'h00, 8'h78, 8'h56});
    check_eq("mid_nwr", 64'(got_addr.size()), 64'd0);
    q = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_case("after_rst", q);

    for (int c = 0; c < 12; c++) begin
      int nfr, kind, len;
      logic [7:0] x, b;
      q.delete();
      repeat ($urandom_range(0, 2)) q.push_back(8'($urandom));
      nfr = $urandom_range(1, 2);
      for (int f = 0; f < nfr; f++) begin
        q.push_back(SYNC);
        kind = $urandom_range(0, 7);
        if (kind == 0) begin
          q.push_back(8'($urandom));
          q.push_back(8'($urandom_range(9, 255)));
        end else begin
          len = $urandom_range(0, 5);
          q.push_back(8'(len));
          q.push_back(8'h00);
          x = 8'h00;
          for (int k = 0; k < 4 * len; k++) begin
            b = 8'($urandom);
            x = x ^ b;
            q.push_back(b);
          end
          q.push_back((kind == 1) ? (x ^ 8'h5A) : x);
        end
      end
      q.push_back(8'($urandom));
      q.push_back(8'($urandom));
      run_case($sformatf("rand%0d", c), q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 SHALL have parameter MEM_WORDS, default 2048: BRAM depth in 32-bit words, which is the maximum accepted length.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rx_valid  input  1  rx_data holds an unread byte.
REQ-007 rx_re  output  1  one-cycle acknowledge pulse that consumes the byte.
REQ-008 cpu_addr  input  11  CPU data-port word address (EX/MEM ALU result [12:2]).
REQ-009 cpu_din  input  32  CPU store data.
REQ-010 cpu_we  input  1  CPU store strobe.
REQ-011 mem_addr  output  11  BRAM port-B address.
REQ-012 mem_din  output  32  BRAM port-B write data.
REQ-013 mem_we  output  4  BRAM port-B byte write enables.
REQ-014 core_hold  output  1  1 holds the core in reset and keeps it off port B.
REQ-015 boot_done  output  1  image loaded and checksum OK.
REQ-016 boot_err  output  1  last frame rejected.

Function
REQ-017 SHALL implement the FSM states IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
REQ-018 Frame format SHALL be: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, then CHK (XOR of all data bytes).
REQ-019 A byte SHALL be accepted only when rx_valid=1, state is not DONE, and rx_re was 0 in the previous cycle (one dead cycle after each acknowledge).
REQ-020 rx_re SHALL pulse high for exactly one cycle, registered, in the cycle after acceptance.
REQ-021 IDLE: SYNC_BYTE SHALL go to LEN_LO; any other byte SHALL be consumed and ignored.
REQ-022 LEN_HI: N=0 SHALL go to CHK; N>MEM_WORDS SHALL go to ERR; otherwise SHALL go to DATA.
REQ-023 DATA: bytes SHALL assemble little-endian (the first byte is bits [7:0]); the XOR accumulator SHALL update with each byte.
REQ-024 On the 4th byte of a word, the block SHALL drive mem_we=4'hF, mem_addr=word index, and mem_din=assembled word for exactly one cycle, in the cycle after acceptance.
REQ-025 Word index SHALL start at 0, increment after each write, and never wrap; after word N-1 the FSM SHALL go to CHK.
REQ-026 CHK: a byte equal to the accumulator SHALL go to DONE; a mismatch SHALL go to ERR.
REQ-027 ERR: boot_err SHALL be 1. A SYNC_BYTE SHALL clear boot_err, clear the counters and accumulator, and go to LEN_LO. Other bytes SHALL be ignored.
REQ-028 DONE SHALL be terminal until reset: boot_done=1, core_hold=0, rx_re=0, and no bytes consumed, so the CPU owns the UART.
REQ-029 core_hold SHALL be 1 in every state except DONE, and SHALL drop to 0 in the first cycle DONE is entered.
REQ-030 Port-B mux: while core_hold=0, mem_addr=cpu_addr, mem_din=cpu_din, and mem_we={4{cpu_we}}. While core_hold=1, the loader drives port B and cpu_we SHALL be ignored.
REQ-031 When the loader is idle on port B, mem_we SHALL be 4'h0; mem_addr and mem_din SHALL hold their last values.
REQ-032 rx_valid deasserted mid-word SHALL stall assembly indefinitely with no timeout and no state change.

Reset
REQ-033 When rst=0 at a clock edge, the block SHALL enter IDLE and clear the word index, byte index and accumulator.
REQ-034 Output values during reset SHALL be: rx_re=0, mem_we=4'h0, mem_addr=0, mem_din=0, core_hold=1, boot_done=0, boot_err=0.
REQ-035 Reset SHALL act mid-frame and from DONE alike: any partial word SHALL be discarded and BRAM contents SHALL be left untouched.

Verification
REQ-036 Bytes A5,01,00,78,56,34,12,08 -> exactly one write: mem_addr=0, mem_din=32'h12345678, mem_we=F; then boot_done=1, core_hold=0.
REQ-037 Bytes 00,FF,A5,02,00, then 8 data bytes 11..88, then a wrong CHK -> writes at addresses 0 and 1, boot_err=1, core_hold=1; then A5,00,00,00 -> boot_done=1, boot_err=0.
REQ-038 Bytes A5,01,08 (N=2049) -> ERR, no writes, boot_err=1.
REQ-039 After DONE, cpu_we=1, cpu_addr=5, cpu_din=DEADBEEF -> mem_we=F, mem_addr=5, mem_din=DEADBEEF in the same cycle; incoming rx bytes leave rx_re=0.
REQ-040 rst=0 after 2 data bytes of a word -> IDLE, no write; a full frame is then accepted from a clean state.
REQ-041 rx_valid held high continuously -> rx_re pulses no more often than every other cycle, and every byte is consumed exactly once.
